// File: rtl/inst_fetch_mem.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_mem
// Purpose  : Instruction memory with a registered, handshaked fetch port and
//            a program-load write port. Optional macro: IMEM_BOUNDS_CHECK_EN
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_mem #(
   parameter int          DEPTH    = 64,
   parameter int          ADDR_W   = 32,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_ready,
   output logic              inst_valid,
   output logic [31:0]       inst,
   input  logic              inst_ready,
   output logic              fault,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [31:0]       load_data
);

   localparam int c_idx_w = $clog2(DEPTH);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [31:0]        r_mem [DEPTH];
   logic [31:0]        r_inst;
   logic               r_fault;
   logic [c_idx_w-1:0] w_fetch_idx;
   logic [c_idx_w-1:0] w_load_idx;
   logic               w_fetch_fault;
   logic               w_load_fault;
   logic               w_accept;
   logic               w_unused_bits;

   assign w_fetch_idx = fetch_addr[2 +: c_idx_w];
   assign w_load_idx  = load_addr[2 +: c_idx_w];

`ifdef IMEM_BOUNDS_CHECK_EN
   // Extra MSB keeps the limit representable when 4*DEPTH == 2**ADDR_W.
   localparam logic [ADDR_W:0] c_limit = (ADDR_W+1)'(4 * DEPTH);
   assign w_fetch_fault = (fetch_addr[1:0] != 2'b00) || ({1'b0, fetch_addr} >= c_limit);
   assign w_load_fault  = (load_addr[1:0]  != 2'b00) || ({1'b0, load_addr}  >= c_limit);
`else
   assign w_fetch_fault = 1'b0;
   assign w_load_fault  = 1'b0;
`endif

   // Address bits outside the word index are only consulted by the bounds check.
   assign w_unused_bits = &{1'b0, fetch_addr, load_addr, NOP_WORD};

   assign fetch_ready = rst_n && !load_en && ((r_state == IDLE) || inst_ready);
   assign w_accept    = fetch_req && fetch_ready;
   assign inst_valid  = (r_state == RESP);
   assign inst        = r_inst;
   assign fault       = r_fault;

   // Storage is deliberately not reset; a load during reset is dropped.
   always_ff @(posedge clk) begin
      if (rst_n && load_en && !w_load_fault) begin
         r_mem[w_load_idx] <= load_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_accept) begin
         w_state_nxt = RESP;
      end else if ((r_state == RESP) && inst_ready) begin
         w_state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_inst  <= 32'h0;
         r_fault <= 1'b0;
      end else if (w_accept) begin
         r_inst  <= w_fetch_fault ? NOP_WORD : r_mem[w_fetch_idx];
         r_fault <= w_fetch_fault;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_mem
// Purpose  : Directed self-checking bench for inst_fetch_mem
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_mem;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        fetch_ready;
   logic        inst_valid;
   logic [31:0] inst;
   logic        inst_ready;
   logic        fault;
   logic        load_en;
   logic [31:0] load_addr;
   logic [31:0] load_data;

   int checks   = 0;
   int failures = 0;

   inst_fetch_mem #(
      .DEPTH    (64),
      .ADDR_W   (32),
      .NOP_WORD (32'h0000_0000)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_ready (fetch_ready),
      .inst_valid  (inst_valid),
      .inst        (inst),
      .inst_ready  (inst_ready),
      .fault       (fault),
      .load_en     (load_en),
      .load_addr   (load_addr),
      .load_data   (load_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are checked there too.
   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      rst_n      = 1'b0;
      fetch_req  = 1'b0;
      fetch_addr = 32'h0;
      inst_ready = 1'b0;
      load_en    = 1'b0;
      load_addr  = 32'h0;
      load_data  = 32'h0;
      step();
      step();
      check("rst_valid", {31'b0, inst_valid}, 32'd0);
      check("rst_inst", inst, 32'h0);
      check("rst_fault", {31'b0, fault}, 32'd0);
      check("rst_ready", {31'b0, fetch_ready}, 32'd0);

      rst_n = 1'b1;
      load_en = 1'b1; load_addr = 32'h00; load_data = 32'hAC000008;
      #1 check("load_blocks_ready", {31'b0, fetch_ready}, 32'd0);
      step();
      load_addr = 32'h04; load_data = 32'hAC210004;
      step();
      load_en = 1'b0;

      // Back-to-back fetches 0x00, 0x04, 0x00 with inst_ready held high
      inst_ready = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h00;
      #1 check("ready_idle", {31'b0, fetch_ready}, 32'd1);
      step();
      check("f0_valid", {31'b0, inst_valid}, 32'd1);
      check("f0_inst", inst, 32'hAC000008);
      check("f0_fault", {31'b0, fault}, 32'd0);
      fetch_addr = 32'h04;
      #1 check("b2b_ready1", {31'b0, fetch_ready}, 32'd1);
      step();
      check("b2b_inst1", inst, 32'hAC210004);
      fetch_addr = 32'h00;
      #1 check("b2b_ready2", {31'b0, fetch_ready}, 32'd1);
      step();
      check("b2b_inst2", inst, 32'hAC000008);
      check("b2b_valid2", {31'b0, inst_valid}, 32'd1);
      fetch_req = 1'b0;
      step();
      check("drain_valid", {31'b0, inst_valid}, 32'd0);

      // Back-pressure: response must hold while inst_ready is low
      fetch_req = 1'b1; fetch_addr = 32'h04; inst_ready = 1'b0;
      step();
      fetch_addr = 32'h00;
      for (int i = 0; i < 3; i++) begin
         check("stall_valid", {31'b0, inst_valid}, 32'd1);
         check("stall_inst", inst, 32'hAC210004);
         check("stall_ready", {31'b0, fetch_ready}, 32'd0);
         step();
      end
      fetch_req = 1'b0; inst_ready = 1'b1;
      step();
      check("stall_consumed", {31'b0, inst_valid}, 32'd0);

      // Same-cycle load and fetch: load wins
      load_en = 1'b1; load_addr = 32'h08; load_data = 32'h12345678;
      fetch_req = 1'b1; fetch_addr = 32'h08;
      #1 check("collide_ready", {31'b0, fetch_ready}, 32'd0);
      step();
      check("collide_noaccept", {31'b0, inst_valid}, 32'd0);
      load_en = 1'b0;
      step();
      check("after_load_inst", inst, 32'h12345678);

      // Load to the held address must not disturb the held word
      fetch_req = 1'b0; inst_ready = 1'b0;
      load_en = 1'b1; load_addr = 32'h08; load_data = 32'hDEADBEEF;
      step();
      check("held_valid", {31'b0, inst_valid}, 32'd1);
      check("held_inst", inst, 32'h12345678);
      load_en = 1'b0; inst_ready = 1'b1;
      step();
      fetch_req = 1'b1; fetch_addr = 32'h08;
      step();
      check("reload_inst", inst, 32'hDEADBEEF);

`ifdef IMEM_BOUNDS_CHECK_EN
      fetch_addr = 32'h102;
      step();
      check("oob_fault", {31'b0, fault}, 32'd1);
      check("oob_inst", inst, 32'h0000_0000);
      fetch_addr = 32'h00;
      step();
      check("inb_fault", {31'b0, fault}, 32'd0);
      check("inb_inst", inst, 32'hAC000008);
`else
      fetch_addr = 32'h100;
      step();
      check("wrap_inst", inst, 32'hAC000008);
      check("wrap_fault", {31'b0, fault}, 32'd0);
      fetch_addr = 32'h107;
      step();
      check("wrap_lowbits_inst", inst, 32'hAC210004);
`endif

      // Reset while holding a response, with a concurrent load that must drop
      fetch_addr = 32'h04; inst_ready = 1'b0;
      step();
      check("pre_rst_valid", {31'b0, inst_valid}, 32'd1);
      fetch_req = 1'b0;
      rst_n = 1'b0;
      load_en = 1'b1; load_addr = 32'h00; load_data = 32'hFFFFFFFF;
      #1 check("rst_ready_low", {31'b0, fetch_ready}, 32'd0);
      step();
      check("mid_rst_valid", {31'b0, inst_valid}, 32'd0);
      check("mid_rst_inst", inst, 32'h0);
      check("mid_rst_fault", {31'b0, fault}, 32'd0);
      rst_n = 1'b1; load_en = 1'b0;
      fetch_req = 1'b1; fetch_addr = 32'h00; inst_ready = 1'b1;
      step();
      check("retained_valid", {31'b0, inst_valid}, 32'd1);
      check("retained_inst", inst, 32'hAC000008);
      fetch_req = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
